qspi_memwb_prefetch: RTL and testbench

QSPI_MEMWB_PREFETCH -- requirements
Module: qspi_memwb_prefetch

---
 rtl/qspi_memwb_prefetch_pkg.sv | 14 +
 rtl/wb_prefetch_fifo.sv | 59 +++++
 rtl/qspi_memwb_prefetch.sv | 130 +++++++++++++
 tb/tb_qspi_memwb_prefetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_memwb_prefetch_pkg.sv
// Shared xspi definitions: memory Wishbone default widths and prefetch FSM states.
package qspi_memwb_prefetch_pkg;

   localparam int unsigned XspiAddrBits = 26;
   localparam int unsigned XspiDataBits = 16;
   localparam int unsigned XspiDepth    = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDrain = 2'd2
   } pf_state_e;

endpackage

// File: rtl/wb_prefetch_fifo.sv
// Prefetch word FIFO: DEPTH x DATABITS registered storage, combinational head read.
module wb_prefetch_fifo #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned DATABITS = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DATABITS-1:0]        dat_i,
   output logic [DATABITS-1:0]        dat_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATABITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                do_push, do_pop;

   always_comb begin
      do_pop  = !flush_i && pop_i && (cnt_q != '0);
      // A full FIFO still accepts a push when the head leaves in the same cycle
      do_push = !flush_i && push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= dat_i;
      end
   end

   assign dat_o   = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/qspi_memwb_prefetch.sv
// Read-prefetch engine: credit-limited pipelined Wishbone B4 burst into a small FIFO.
module qspi_memwb_prefetch
   import qspi_memwb_prefetch_pkg::*;
#(
   parameter int unsigned ADDRBITS = XspiAddrBits,
   parameter int unsigned DATABITS = XspiDataBits,
   parameter int unsigned DEPTH    = XspiDepth
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [ADDRBITS-1:0] start_adr_i,
   input  logic                abort_i,
   input  logic                rd_req_i,
   output logic [DATABITS-1:0] rd_dat_o,
   output logic                rd_valid_o,
   output logic                rd_err_o,
   output logic                busy_o,
   output logic                memwb_cyc_o,
   output logic                memwb_stb_o,
   output logic                memwb_we_o,
   output logic [ADDRBITS-1:0] memwb_adr_o,
   input  logic                memwb_ack_i,
   input  logic                memwb_err_i,
   input  logic                memwb_stall_i,
   input  logic [DATABITS-1:0] memwb_dat_i
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);

   pf_state_e           st_q, st_d;
   logic [ADDRBITS-1:0] adr_q, adr_d;
   logic [CntW-1:0]     outst_q, outst_d;
   logic [CntW-1:0]     fifo_cnt, cnt_nxt;
   logic                err_q, err_d, cyc_q, cyc_d, stb_q, stb_d;
   logic                push, pop, flush, accept, resp_ok;

   always_comb begin
      st_d    = st_q;
      adr_d   = adr_q;
      err_d   = err_q;
      push    = 1'b0;
      flush   = 1'b0;
      accept  = stb_q && !memwb_stall_i;
      // Stray responses with nothing outstanding are dropped, so the counter never underflows
      resp_ok = (memwb_ack_i || memwb_err_i) && (outst_q != '0);
      pop     = rd_req_i && (fifo_cnt != '0);
      outst_d = outst_q + CntW'(accept) - CntW'(resp_ok);
      if (accept) begin
         adr_d = adr_q + ADDRBITS'(1);
      end

      unique case (st_q)
         StIdle: begin
            if (abort_i) begin
               flush = 1'b1;
            end else if (start_i) begin
               flush = 1'b1;
               adr_d = start_adr_i;
               err_d = 1'b0;
               st_d  = StFetch;
            end
         end
         StFetch: begin
            if (abort_i) begin
               flush = 1'b1;
               st_d  = (outst_d != '0) ? StDrain : StIdle;
            end else if (memwb_err_i && resp_ok) begin
               err_d = 1'b1;
               st_d  = StDrain;
            end else if (memwb_ack_i && resp_ok) begin
               push = 1'b1;
            end
         end
         StDrain: begin
            if (outst_d == '0) begin
               st_d = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase

      cnt_nxt = flush ? '0 : (fifo_cnt + CntW'(push) - CntW'(pop));
      cyc_d   = (st_d != StIdle);
      // Credit rule: never request more than the FIFO can still absorb
      stb_d   = (st_d == StFetch) && (({1'b0, cnt_nxt} + {1'b0, outst_d}) < DepthSum);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q    <= StIdle;
         adr_q   <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         adr_q   <= adr_d;
         outst_q <= outst_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
      end
   end

   wb_prefetch_fifo #(
      .DEPTH    (DEPTH),
      .DATABITS (DATABITS)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .dat_i   (memwb_dat_i),
      .dat_o   (rd_dat_o),
      .count_o (fifo_cnt)
   );

   assign rd_valid_o  = (fifo_cnt != '0);
   assign rd_err_o    = err_q;
   assign busy_o      = (st_q != StIdle);
   assign memwb_cyc_o = cyc_q;
   assign memwb_stb_o = stb_q;
   assign memwb_we_o  = 1'b0;
   assign memwb_adr_o = adr_q;

endmodule

// File: tb/tb_qspi_memwb_prefetch.sv
// Bench for qspi_memwb_prefetch: latency-programmable Wishbone slave model plus read scoreboard.
module tb_qspi_memwb_prefetch;

   localparam int unsigned AB = 26;
   localparam int unsigned DB = 16;
   localparam int unsigned DP = 4;

   logic          clk_i = 1'b0;
   logic          rst_i, start_i, abort_i, rd_req_i;
   logic [AB-1:0] start_adr_i;
   logic [DB-1:0] rd_dat_o;
   logic          rd_valid_o, rd_err_o, busy_o;
   logic          memwb_cyc_o, memwb_stb_o, memwb_we_o;
   logic [AB-1:0] memwb_adr_o;
   logic          memwb_ack_i, memwb_err_i, memwb_stall_i;
   logic [DB-1:0] memwb_dat_i;

   qspi_memwb_prefetch #(
      .ADDRBITS (AB),
      .DATABITS (DB),
      .DEPTH    (DP)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .start_adr_i   (start_adr_i),
      .abort_i       (abort_i),
      .rd_req_i      (rd_req_i),
      .rd_dat_o      (rd_dat_o),
      .rd_valid_o    (rd_valid_o),
      .rd_err_o      (rd_err_o),
      .busy_o        (busy_o),
      .memwb_cyc_o   (memwb_cyc_o),
      .memwb_stb_o   (memwb_stb_o),
      .memwb_we_o    (memwb_we_o),
      .memwb_adr_o   (memwb_adr_o),
      .memwb_ack_i   (memwb_ack_i),
      .memwb_err_i   (memwb_err_i),
      .memwb_stall_i (memwb_stall_i),
      .memwb_dat_i   (memwb_dat_i)
   );

   always #5 clk_i = ~clk_i;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DB-1:0] exp_q[$];
   logic [AB-1:0] pend_adr[$];
   int            pend_due[$];
   int            cyc_n = 0, lat = 0, err_at = 0, n_resp = 0, n_acc = 0;
   int            max_infl = 0, n_pop = 0;
   bit            rd_en = 1'b0;
   logic [DB-1:0] mon_e;
   logic [AB-1:0] slv_a;

   function automatic logic [DB-1:0] wdat(input logic [AB-1:0] a);
      return a[15:0] ^ {a[25:16], 6'h15};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic [AB-1:0] a);
      start_i     = 1'b1;
      start_adr_i = a;
      tick(1);
      start_i     = 1'b0;
   endtask

   task automatic do_abort();
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string name);
      for (int i = 0; i < bound && busy_o; i++) tick(1);
      check(name, 32'(busy_o), 32'd0);
   endtask

   task automatic wait_exp_empty(input int bound, input string name);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) tick(1);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Slave: record accepted requests (sampled mid-cycle, accepted at the next edge)
   initial forever begin
      @(negedge clk_i);
      if (!rst_i) begin
         if (pend_adr.size() + ((memwb_ack_i || memwb_err_i) ? 1 : 0) > max_infl)
            max_infl = pend_adr.size() + ((memwb_ack_i || memwb_err_i) ? 1 : 0);
         if (memwb_cyc_o && memwb_stb_o && !memwb_stall_i) begin
            pend_adr.push_back(memwb_adr_o);
            pend_due.push_back(cyc_n + 1 + lat);
            n_acc++;
         end
      end
   end

   // Slave: drive one response per cycle once due
   initial begin
      memwb_ack_i = 1'b0;
      memwb_err_i = 1'b0;
      memwb_dat_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         cyc_n++;
         memwb_ack_i = 1'b0;
         memwb_err_i = 1'b0;
         if (rst_i) begin
            pend_adr.delete();
            pend_due.delete();
         end else if (pend_due.size() != 0 && pend_due[0] <= cyc_n) begin
            slv_a = pend_adr.pop_front();
            void'(pend_due.pop_front());
            n_resp++;
            if (n_resp == err_at) begin
               memwb_err_i = 1'b1;
            end else begin
               memwb_ack_i = 1'b1;
               memwb_dat_i = wdat(slv_a);
            end
         end
      end
   end

   // Consumer: request only while words are still expected
   initial begin
      rd_req_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         rd_req_i = rd_en && (exp_q.size() != 0);
      end
   end

   // Monitor: every popped word is checked against the scoreboard
   initial forever begin
      @(negedge clk_i);
      if (!rst_i && rd_req_i && rd_valid_o) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_dat: unexpected word 0x%0h, none expected", rd_dat_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("rd_dat", 32'(rd_dat_o), 32'(mon_e));
            n_pop++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int a0, p0, acks;

   initial begin
      rst_i         = 1'b1;
      start_i       = 1'b0;
      abort_i       = 1'b0;
      start_adr_i   = '0;
      memwb_stall_i = 1'b0;
      tick(3);
      check("rst_busy",  32'(busy_o),      32'd0);
      check("rst_cyc",   32'(memwb_cyc_o), 32'd0);
      check("rst_stb",   32'(memwb_stb_o), 32'd0);
      check("rst_we",    32'(memwb_we_o),  32'd0);
      check("rst_valid", 32'(rd_valid_o),  32'd0);
      check("rst_err",   32'(rd_err_o),    32'd0);
      check("rst_adr",   32'(memwb_adr_o), 32'd0);
      rst_i = 1'b0;
      tick(2);

      // Zero-latency burst from 0x100 with continuous consumption
      lat      = 0;
      rd_en    = 1'b1;
      max_infl = 0;
      for (int i = 0; i < 16; i++) exp_q.push_back(wdat(AB'(32'h100 + i)));
      do_start(AB'(32'h100));
      check("t1_cyc_after_start", 32'(memwb_cyc_o), 32'd1);
      check("t1_stb_after_start", 32'(memwb_stb_o), 32'd1);
      wait_exp_empty(300, "t1_all_words");
      check("t1_inflight_over_depth", 32'(max_infl > DP), 32'd0);
      do_abort();
      wait_idle(40, "t1_idle");
      check("t1_valid_after_abort", 32'(rd_valid_o), 32'd0);

      // Address wrap at the top of the 26-bit space
      exp_q.push_back(wdat(AB'(32'h3FFFFFE)));
      exp_q.push_back(wdat(AB'(32'h3FFFFFF)));
      exp_q.push_back(wdat(AB'(32'h0000000)));
      exp_q.push_back(wdat(AB'(32'h0000001)));
      do_start(AB'(32'h3FFFFFE));
      check("t2_first_adr", 32'(memwb_adr_o), 32'h3FFFFFE);
      wait_exp_empty(100, "t2_wrap_words");
      do_abort();
      wait_idle(40, "t2_idle");

      // No consumption: exactly DEPTH requests, then credit stalls the strobe
      rd_en = 1'b0;
      a0    = n_acc;
      do_start(AB'(32'h200));
      tick(20);
      check("t3_requests",  32'(n_acc - a0),           32'd4);
      check("t3_stb_low",   32'(memwb_stb_o),          32'd0);
      check("t3_cyc_high",  32'(memwb_cyc_o),          32'd1);
      check("t3_valid",     32'(rd_valid_o),           32'd1);
      check("t3_count",     32'(dut.u_fifo.count_o),   32'd4);
      for (int i = 0; i < 4; i++) exp_q.push_back(wdat(AB'(32'h200 + i)));
      rd_en = 1'b1;
      wait_exp_empty(100, "t3_words");
      rd_en = 1'b0;
      do_abort();
      wait_idle(40, "t3_idle");

      // Abort with three requests outstanding; slow slave
      lat           = 4;
      memwb_stall_i = 1'b1;
      do_start(AB'(32'h500));
      a0            = n_acc;
      memwb_stall_i = 1'b0;
      tick(3);
      memwb_stall_i = 1'b1;
      do_abort();
      check("t4_accepted",   32'(n_acc - a0),  32'd3);
      check("t4_stb_low",    32'(memwb_stb_o), 32'd0);
      check("t4_cyc_held",   32'(memwb_cyc_o), 32'd1);
      check("t4_valid_flush", 32'(rd_valid_o), 32'd0);
      acks = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (!memwb_cyc_o) break;
         if (memwb_ack_i) acks++;
      end
      check("t4_acks_under_cyc", 32'(acks), 32'd3);
      check("t4_cyc_dropped", 32'(memwb_cyc_o), 32'd0);
      tick(1);
      check("t4_no_push", 32'(rd_valid_o), 32'd0);
      check("t4_busy", 32'(busy_o), 32'd0);
      lat           = 0;
      memwb_stall_i = 1'b0;

      // Bus error on the second response
      err_at = n_resp + 2;
      rd_en  = 1'b1;
      p0     = n_pop;
      exp_q.push_back(wdat(AB'(32'h300)));
      do_start(AB'(32'h300));
      wait_idle(40, "t5_idle");
      tick(2);
      check("t5_err_flag",  32'(rd_err_o),     32'd1);
      check("t5_delivered", 32'(n_pop - p0),   32'd1);
      check("t5_exp_left",  32'(exp_q.size()), 32'd0);
      check("t5_valid",     32'(rd_valid_o),   32'd0);
      err_at = 0;
      rd_en  = 1'b0;
      do_start(AB'(32'h400));
      check("t5_err_cleared", 32'(rd_err_o), 32'd0);
      check("t5_busy_again",  32'(busy_o),   32'd1);
      do_abort();
      wait_idle(40, "t5_idle2");

      // Asynchronous reset in the middle of a stalled fetch
      memwb_stall_i = 1'b1;
      do_start(AB'(32'h600));
      tick(2);
      check("t6_cyc_pre", 32'(memwb_cyc_o), 32'd1);
      check("t6_stb_pre", 32'(memwb_stb_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check("t6_cyc_rst",   32'(memwb_cyc_o), 32'd0);
      check("t6_stb_rst",   32'(memwb_stb_o), 32'd0);
      check("t6_busy_rst",  32'(busy_o),      32'd0);
      check("t6_valid_rst", 32'(rd_valid_o),  32'd0);
      tick(1);
      rst_i         = 1'b0;
      memwb_stall_i = 1'b0;
      tick(3);
      check("t6_idle_after", 32'(busy_o),      32'd0);
      check("t6_adr_after",  32'(memwb_adr_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
